// File: rtl/vec_acc_ctrl.sv
// Vector accelerator issue controller: accepts scalar-core requests, forwards them to the
// vector decoder with a reorder-buffer tag, and returns completions to the core in acceptance order.
module vec_acc_ctrl #(
    parameter  int DEPTH         = 4,
    parameter  int TRANS_ID_BITS = 4,
    localparam int TAG_W         = $clog2(DEPTH),
    localparam int REQ_W         = 96 + TRANS_ID_BITS,
    localparam int RESP_W        = 33 + TRANS_ID_BITS
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // Every channel is strict valid/ready: a transfer happens on a rising edge where both are 1,
    // and a producer holds valid and its payload stable until that transfer.
    // req_i = {instr[31:0], rs1[31:0], rs2[31:0], instr_id}
    input  logic               req_valid_i,
    input  logic [REQ_W-1:0]   req_i,
    output logic               req_ready_o,
    output logic               dec_valid_o,
    input  logic               dec_ready_i,
    output logic [31:0]        dec_instr_o,
    output logic [31:0]        dec_rs1_o,
    output logic [31:0]        dec_rs2_o,
    output logic [TAG_W-1:0]   dec_tag_o,
    input  logic               cmpl_valid_i,
    input  logic [TAG_W-1:0]   cmpl_tag_i,
    input  logic               cmpl_err_i,
    input  logic [31:0]        cmpl_res_i,
    // resp_o = {err, res[31:0], instr_id}
    output logic               resp_valid_o,
    output logic [RESP_W-1:0]  resp_o,
    input  logic               resp_ready_i
);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_ISSUED, SLOT_DONE} slot_e;

    slot_e                    slot_q [DEPTH];
    slot_e                    slot_d [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_q   [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_d   [DEPTH];
    logic [31:0]              res_q  [DEPTH];
    logic [31:0]              res_d  [DEPTH];
    logic                     err_q  [DEPTH];
    logic                     err_d  [DEPTH];

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   occ_q, occ_d;
    logic             dec_valid_q, dec_valid_d;
    logic [31:0]      dec_instr_q, dec_instr_d, dec_rs1_q, dec_rs1_d, dec_rs2_q, dec_rs2_d;
    logic [TAG_W-1:0] dec_tag_q, dec_tag_d;
    logic             ready_en_q, ready_en_d;

    logic accept, retire, cmpl_ok;

    // ready_en_q keeps req_ready_o low while reset is held and for the cycle of release.
    assign req_ready_o  = ready_en_q && (occ_q < (TAG_W+1)'(DEPTH)) && (!dec_valid_q || dec_ready_i);
    assign resp_valid_o = (slot_q[head_q] == SLOT_DONE);
    assign resp_o       = {err_q[head_q], res_q[head_q], id_q[head_q]};
    assign dec_valid_o  = dec_valid_q;
    assign dec_instr_o  = dec_instr_q;
    assign dec_rs1_o    = dec_rs1_q;
    assign dec_rs2_o    = dec_rs2_q;
    assign dec_tag_o    = dec_tag_q;

    assign accept  = req_valid_i && req_ready_o;
    assign retire  = resp_valid_o && resp_ready_i;
    assign cmpl_ok = cmpl_valid_i && (slot_q[cmpl_tag_i] == SLOT_ISSUED);

    always_comb begin
        slot_d      = slot_q;
        id_d        = id_q;
        res_d       = res_q;
        err_d       = err_q;
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        dec_valid_d = dec_valid_q;
        dec_instr_d = dec_instr_q;
        dec_rs1_d   = dec_rs1_q;
        dec_rs2_d   = dec_rs2_q;
        dec_tag_d   = dec_tag_q;
        ready_en_d  = 1'b1;

        if (retire) begin
            slot_d[head_q] = SLOT_FREE;
            head_d         = head_q + TAG_W'(1);
        end
        // A DONE head cannot also be ISSUED, so completion never collides with the retiring slot.
        if (cmpl_ok) begin
            slot_d[cmpl_tag_i] = SLOT_DONE;
            res_d[cmpl_tag_i]  = cmpl_res_i;
            err_d[cmpl_tag_i]  = cmpl_err_i;
        end
        if (accept) begin
            slot_d[tail_q] = SLOT_ISSUED;
            id_d[tail_q]   = req_i[TRANS_ID_BITS-1:0];
            tail_d         = tail_q + TAG_W'(1);
            dec_valid_d    = 1'b1;
            dec_instr_d    = req_i[REQ_W-1 -: 32];
            dec_rs1_d      = req_i[TRANS_ID_BITS+63 -: 32];
            dec_rs2_d      = req_i[TRANS_ID_BITS+31 -: 32];
            dec_tag_d      = tail_q;
        end else if (dec_valid_q && dec_ready_i) begin
            dec_valid_d = 1'b0;
        end

        case ({accept, retire})
            2'b10:   occ_d = occ_q + (TAG_W+1)'(1);
            2'b01:   occ_d = occ_q - (TAG_W+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_FREE;
                id_q[i]   <= '0;
                res_q[i]  <= '0;
                err_q[i]  <= 1'b0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= '0;
            dec_rs1_q   <= '0;
            dec_rs2_q   <= '0;
            dec_tag_q   <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            id_q        <= id_d;
            res_q       <= res_d;
            err_q       <= err_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_rs1_q   <= dec_rs1_d;
            dec_rs2_q   <= dec_rs2_d;
            dec_tag_q   <= dec_tag_d;
            ready_en_q  <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_vec_acc_ctrl.sv
// Bench for vec_acc_ctrl: expected responses are queued at acceptance and compared in order
// as the controller retires them; directed scenarios cover ordering, full, backpressure and reset.
module tb_vec_acc_ctrl;

    localparam int DEPTH  = 4;
    localparam int IDW    = 4;
    localparam int TAG_W  = 2;
    localparam int RESP_W = 33 + IDW;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_valid_i = 1'b0;
    logic [96+IDW-1:0] req_i = '0;
    logic              req_ready_o;
    logic              dec_valid_o;
    logic              dec_ready_i = 1'b1;
    logic [31:0]       dec_instr_o, dec_rs1_o, dec_rs2_o;
    logic [TAG_W-1:0]  dec_tag_o;
    logic              cmpl_valid_i = 1'b0;
    logic [TAG_W-1:0]  cmpl_tag_i = '0;
    logic              cmpl_err_i = 1'b0;
    logic [31:0]       cmpl_res_i = '0;
    logic              resp_valid_o;
    logic [RESP_W-1:0] resp_o;
    logic              resp_ready_i = 1'b1;

    vec_acc_ctrl #(.DEPTH(DEPTH), .TRANS_ID_BITS(IDW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_i(req_i), .req_ready_o(req_ready_o),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_instr_o(dec_instr_o), .dec_rs1_o(dec_rs1_o), .dec_rs2_o(dec_rs2_o), .dec_tag_o(dec_tag_o),
        .cmpl_valid_i(cmpl_valid_i), .cmpl_tag_i(cmpl_tag_i), .cmpl_err_i(cmpl_err_i), .cmpl_res_i(cmpl_res_i),
        .resp_valid_o(resp_valid_o), .resp_o(resp_o), .resp_ready_i(resp_ready_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RESP_W-1:0] exp_q[$];
    logic [TAG_W-1:0]  m_tail;
    logic [31:0]       m_res [DEPTH];
    logic              m_err [DEPTH];
    logic [TAG_W-1:0]  last_tag;
    logic [31:0]       last_instr, last_rs1, last_rs2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every retiring handshake must match the oldest queued response
    always @(negedge clk_i) begin
        if (rst_ni && resp_valid_o && resp_ready_i) begin
            if (exp_q.size() == 0) check("resp_unexpected", 64'(resp_o), 64'h0);
            else check("resp_order", 64'(resp_o), 64'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic do_reset();
        #2 rst_ni = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'h0);
        check("rst_dec_valid", 64'(dec_valid_o), 64'h0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'h0);
        check("rst_dec_fields", {dec_instr_o, dec_rs1_o[29:0], dec_tag_o}, 64'h0);
        check("rst_dec_rs2", 64'(dec_rs2_o), 64'h0);
        exp_q.delete();
        m_tail = '0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i);
        #1 check("post_rst_req_ready", 64'(req_ready_o), 64'h1);
    endtask

    task automatic do_accept(input logic [IDW-1:0] id, input logic [31:0] res, input logic err);
        int n;
        @(posedge clk_i);
        #1;
        last_instr = $urandom;
        last_rs1   = $urandom;
        last_rs2   = $urandom;
        req_i = {last_instr, last_rs1, last_rs2, id};
        req_valid_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'h0, 64'h1);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        last_tag = m_tail;
        m_res[m_tail] = res;
        m_err[m_tail] = err;
        exp_q.push_back({err, res, id});
        m_tail = m_tail + 2'd1;
        check("dec_valid", 64'(dec_valid_o), 64'h1);
        check("dec_tag", 64'(dec_tag_o), 64'(last_tag));
        check("dec_instr", 64'(dec_instr_o), 64'(last_instr));
        check("dec_rs", {dec_rs1_o, dec_rs2_o}, {last_rs1, last_rs2});
    endtask

    task automatic raw_cmpl(input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic err);
        @(posedge clk_i);
        #1;
        cmpl_valid_i = 1'b1;
        cmpl_tag_i   = tag;
        cmpl_res_i   = res;
        cmpl_err_i   = err;
        @(posedge clk_i);
        #1 cmpl_valid_i = 1'b0;
    endtask

    task automatic do_cmpl(input logic [TAG_W-1:0] tag);
        raw_cmpl(tag, m_res[tag], m_err[tag]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        do_reset();

        // single op
        do_accept(4'd5, 32'h0000_CAFE, 1'b0);
        @(negedge clk_i) check("single_no_early_resp", 64'(resp_valid_o), 64'h0);
        do_cmpl(2'd0);
        check("single_resp_valid", 64'(resp_valid_o), 64'h1);
        drain();

        // out-of-order completion, in-order response
        do_reset();
        do_accept(4'd1, $urandom, 1'b0);
        do_accept(4'd2, $urandom, 1'b1);
        do_accept(4'd3, $urandom, 1'b0);
        do_cmpl(2'd2);
        check("ooo_wait_t2", 64'(resp_valid_o), 64'h0);
        do_cmpl(2'd1);
        check("ooo_wait_t1", 64'(resp_valid_o), 64'h0);
        do_cmpl(2'd0);
        check("ooo_head_done", 64'(resp_valid_o), 64'h1);
        drain();

        // full buffer and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_accept(IDW'(i + 8), $urandom, 1'($urandom_range(0, 1)));
        check("full_not_ready", 64'(req_ready_o), 64'h0);
        resp_ready_i = 1'b0;
        do_cmpl(2'd0);
        check("full_head_done", 64'(resp_valid_o), 64'h1);
        resp_ready_i = 1'b1;
        @(negedge clk_i) check("full_retire_cycle_ready", 64'(req_ready_o), 64'h0);
        @(posedge clk_i);
        #1 resp_ready_i = 1'b0;
        check("full_ready_after_retire", 64'(req_ready_o), 64'h1);
        do_accept(4'd12, $urandom, 1'b0);
        check("full_wrap_tag", 64'(dec_tag_o), 64'h0);
        resp_ready_i = 1'b1;
        for (int t = 1; t <= DEPTH; t++) do_cmpl(TAG_W'(t));
        drain();

        // decoder and response backpressure
        dec_ready_i = 1'b0;
        do_accept(4'd7, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_dec_valid", 64'(dec_valid_o), 64'h1);
            check("bp_dec_stable", {dec_instr_o, dec_rs2_o}, {last_instr, last_rs2});
            check("bp_dec_tag", 64'(dec_tag_o), 64'(last_tag));
            check("bp_req_ready", 64'(req_ready_o), 64'h0);
        end
        dec_ready_i = 1'b1;
        @(posedge clk_i);
        #1 check("bp_dec_released", 64'(dec_valid_o), 64'h0);
        resp_ready_i = 1'b0;
        do_cmpl(last_tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_resp_valid", 64'(resp_valid_o), 64'h1);
            check("bp_resp_stable", 64'(resp_o), 64'(exp_q[0]));
        end
        @(posedge clk_i);
        #1 resp_ready_i = 1'b1;
        drain();

        // spurious completions: FREE slot, then already-DONE slot
        raw_cmpl(2'd2, 32'h0000_DEAD, 1'b0);
        check("spur_free_resp", 64'(resp_valid_o), 64'h0);
        @(negedge clk_i) check("spur_free_resp_later", 64'(resp_valid_o), 64'h0);
        resp_ready_i = 1'b0;
        do_accept(4'd4, 32'h1234_5678, 1'b0);
        do_accept(4'd6, $urandom, 1'b0);
        do_cmpl(last_tag - 2'd1);
        raw_cmpl(last_tag - 2'd1, 32'h0000_DEAD, 1'b1);
        @(negedge clk_i) check("spur_done_ignored", 64'(resp_o), 64'(exp_q[0]));
        @(posedge clk_i);
        #1 resp_ready_i = 1'b1;
        do_cmpl(last_tag);
        drain();

        // reset mid-flight discards everything
        resp_ready_i = 1'b0;
        do_accept(4'd10, $urandom, 1'b0);
        do_accept(4'd11, $urandom, 1'b0);
        do_accept(4'd13, $urandom, 1'b0);
        do_cmpl(last_tag - 2'd2);
        check("mid_head_done", 64'(resp_valid_o), 64'h1);
        do_reset();
        resp_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        check("mid_no_stale_resp", 64'(resp_valid_o), 64'h0);
        do_accept(4'd9, $urandom, 1'b0);
        check("mid_restart_tag", 64'(dec_tag_o), 64'h0);
        do_cmpl(2'd0);
        drain();

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/vec_acc_ctrl.md
VEC_ACC_CTRL -- requirements
Module: vec_acc_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, outstanding-instruction capacity (power of 2, >=2); TRANS_ID_BITS, 4, width of instr_id in sca_req_t/sca_resp_t.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  in  1  scalar core offers a request.
REQ-005 req_i  in  sca_req_t  instr, rs1, rs2, instr_id from scalar core.
REQ-006 req_ready_o  out  1  controller accepts req_i this cycle.
REQ-007 dec_valid_o  out  1  instruction presented to vector decoder.
REQ-008 dec_ready_i  in  1  decoder accepts.
REQ-009 dec_instr_o / dec_rs1_o / dec_rs2_o  out  32/32/32  registered copy of accepted instr/rs1/rs2.
REQ-010 dec_tag_o  out  log2(DEPTH)  reorder-buffer slot assigned to the instruction.
REQ-011 cmpl_valid_i  in  1  vector unit reports completion.
REQ-012 cmpl_tag_i / cmpl_err_i / cmpl_res_i  in  log2(DEPTH)/1/32  slot, error flag, result.
REQ-013 resp_valid_o  out  1  in-order response available.
REQ-014 resp_o  out  sca_resp_t  err, res, instr_id of head slot.
REQ-015 resp_ready_i  in  1  scalar core accepts response.

Function
REQ-016 Reorder buffer SHALL hold DEPTH slots, each FREE, ISSUED or DONE, with stored instr_id, res, err; head/tail pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-017 req_ready_o SHALL equal (occupancy < DEPTH) AND (NOT dec_valid_o OR dec_ready_i); retirement in the same cycle SHALL NOT free a slot for acceptance that cycle.
REQ-018 On req_valid_i AND req_ready_o: tail slot -> ISSUED, instr_id stored, dec_* registered with dec_tag_o = old tail, tail increments, dec_valid_o = 1 next cycle (1-cycle latency).
REQ-019 dec_valid_o and dec_* SHALL hold stable until dec_valid_o AND dec_ready_i; then dec_valid_o clears unless a new request is accepted in the same cycle.
REQ-020 On cmpl_valid_i with slot cmpl_tag_i ISSUED: slot -> DONE, res/err captured; completion to a FREE or DONE slot SHALL be ignored without state change.
REQ-021 resp_valid_o SHALL be 1 iff head slot is DONE (registered state; completion at cycle N visible at N+1); resp_o SHALL present head slot contents.
REQ-022 On resp_valid_o AND resp_ready_i: head slot -> FREE, head increments, occupancy decrements.
REQ-023 resp_o SHALL hold stable while resp_valid_o AND NOT resp_ready_i.
REQ-024 Responses SHALL return in acceptance order regardless of completion order.
REQ-025 Simultaneous accept, completion and retire in one cycle SHALL all take effect; occupancy changes by (+accept - retire).
REQ-026 Completion of the head slot in the same cycle as its... retire is impossible (retire requires DONE); completion of a non-head slot during retire SHALL be applied.

Reset
REQ-027 While rst_ni = 0: all slots FREE, head = tail = 0, occupancy = 0, dec_valid_o = 0, resp_valid_o = 0, dec_instr_o/dec_rs1_o/dec_rs2_o/dec_tag_o = 0, req_ready_o = 0 during reset and 1 from first cycle after release.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding instructions and pending responses; no response for them SHALL ever appear.

Verification
REQ-029 Single op: accept instr_id=5 at cycle 0, dec_ready_i=1 -> dec_valid_o=1, dec_tag_o=0 at cycle 1; cmpl tag 0 res=0xCAFE at cycle 3 -> resp_valid_o=1 cycle 4, resp_o.instr_id=5, res=0xCAFE, err=0.
REQ-030 Out-of-order: accept ids 1,2,3 (tags 0,1,2); complete tags 2,1,0 -> responses emerge in order ids 1,2,3.
REQ-031 Full: DEPTH=4, four accepts, no completions -> req_ready_o=0; complete tag 0 and retire -> req_ready_o=1 the cycle after retire; fifth accept gets tag 0 (wrap).
REQ-032 Backpressure: dec_ready_i=0 for 3 cycles -> dec_* stable, req_ready_o=0; resp_ready_i=0 -> resp_o stable.
REQ-033 Spurious completion: cmpl_valid_i with tag of FREE slot, res=0xDEAD -> no resp_valid_o, state unchanged.
REQ-034 Reset mid-flight: two ISSUED, one DONE, pull rst_ni low asynchronously -> all outputs reset values immediately; after release, next accept gets tag 0.
